mem_bus_arb: RTL and testbench
==============================

// Module: mem_bus_arb
// PURPOSE
//  Shares the single accelerator memory port among the bus interface units (imap, weight, omap).
//  Each requester holds req_i for a whole session; grants are round-robin, one owner at a time.
//  Commands from the owner pass to memory, and responses route back to it.
//  Tracks outstanding responses; the grant is released only after the owner drops req and all its responses have returned.
// PARAMETERS
//  NREQ     3   number of requesters (index 0 = highest priority after reset)
//  AW       32  address width
//  DW       32  data width
//  OST_MAX  4   max outstanding (issued, unanswered) commands; OSTW = $clog2(OST_MAX+1)
// PORTS
//  clk             in   1        clock
//  rst_n           in   1        reset, synchronous, active-low
//  req_i           in   NREQ     per-requester session request (level)
//  cmd_vld_i       in   NREQ     command valid
//  cmd_rdy_o       out  NREQ     command ready
//  cmd_addr_i      in   NREQ*AW  packed addresses, requester k at [k*AW +: AW]
//  cmd_data_i      in   NREQ*DW  packed write data
//  cmd_we_i        in   NREQ     1 = write, 0 = read
//  rsp_vld_o       out  NREQ     response valid, owner bit only
//  rsp_rdy_i       in   NREQ     response ready
//  rsp_data_o      out  DW       response data (broadcast; qualified by rsp_vld_o)
//  mem_cmd_vld_o   out  1        memory command valid
//  mem_cmd_rdy_i   in   1        memory command ready
//  mem_cmd_addr_o  out  AW       memory address
//  mem_cmd_data_o  out  DW       memory write data
//  mem_cmd_we_o    out  1        memory write enable
//  mem_rsp_vld_i   in   1        memory response valid
//  mem_rsp_rdy_o   out  1        memory response ready
//  mem_rsp_data_i  in   DW       memory response data
//  grant_o         out  NREQ     one-hot current owner (0 = none)
//  err_o           out  1        sticky: response received with zero outstanding
// BEHAVIOUR
//  - Reset: state=IDLE, grant_o=0, rr pointer=0, ost_cnt=0, err_o=0; all vld/rdy outputs 0.
//    Reset mid-session drops everything; in-flight responses are not tracked.
//  - FSM IDLE: if any req_i, pick first requester at or after ptr (wrapping); register grant -> GRANT.
//    The grant is visible one cycle after req seen. ptr <= winner+1 mod NREQ.
//  - FSM GRANT: owner cmd muxed combinationally to mem_cmd_*.
//    mem_cmd_vld_o = cmd_vld_i[own] & (ost_cnt<OST_MAX).
//    cmd_rdy_o[own] = mem_cmd_rdy_i & (ost_cnt<OST_MAX); non-owners get rdy 0.
//  - Response routing in GRANT/DRAIN: rsp_vld_o[own] = mem_rsp_vld_i; mem_rsp_rdy_o = rsp_rdy_i[own].
//  - ost_cnt: +1 on cmd handshake, -1 on rsp handshake, unchanged on both same cycle; never exceeds OST_MAX.
//  - Owner drops req_i in GRANT: if ost_cnt==0 (after this cycle's update) -> IDLE, else -> DRAIN.
//    Command handshakes are still honoured in the cycle req falls.
//  - DRAIN: no commands accepted (mem_cmd_vld_o=0); responses still routed to the owner.
//    When ost_cnt reaches 0 -> IDLE, grant_o cleared.
//  - Re-raising req in DRAIN does not extend the session; the requester re-arbitrates from IDLE.
//  - Spurious response (mem_rsp_vld_i while ost_cnt==0 or in IDLE): mem_rsp_rdy_o=1, data dropped, err_o<=1 (cleared by reset only).
//  - IDLE->grant bubble of 1 cycle per session; no combinational path from mem_*_rdy_i to mem_*_vld_o.
// CONFIGURATION
//  - Macro MEM_BUS_ARB_PERF_EN defined: adds output perf_busy_o [NREQ*32].
//    Requester k's 32-bit counter increments every cycle grant_o[k]=1, saturates at 32'hFFFFFFFF, and resets to 0.
//  - Macro undefined: port and counters absent; other behaviour identical.
// STRUCTURE
//  - Package mem_arb_pkg: FSM state localparams (IDLE=2'd0, GRANT=2'd1, DRAIN=2'd2), default NREQ/AW/DW, function onehot2idx.
//  - Sub-module mem_rr_pick: combinational round-robin picker (req vector, ptr) -> one-hot winner + index.
//  - Top holds FSM, ost counter, muxes, err flag, optional perf counters.
// TESTING
//  - Single req: req_i=3'b100 -> grant_o=3'b100 next cycle; 8 writes A=0x1000.. pass through;
//    drop req after last rsp -> IDLE, grant_o=0.
//  - Contention: req_i=3'b111 held, each releases after 2 cmds -> grant order 0,1,2,0.
//    Then only req1 -> grant 1 (ptr wrap correct).
//  - Backpressure: mem_rsp_vld_i held 0, owner streams 6 reads -> exactly 4 accepted, cmd_rdy_o=0 while ost_cnt=4.
//    One response -> one more accepted.
//  - Drain: owner drops req with ost_cnt=3 -> DRAIN, grant_o stays, mem_cmd_vld_o=0.
//    Other req waits until 3rd rsp, then is granted 1 cycle after IDLE.
//  - Simultaneous cmd+rsp handshake at ost_cnt=4 (rdy gated) and at ost_cnt=2 -> count stays 2.
//    Spurious rsp in IDLE -> err_o=1, rsp dropped.
//  - Reset asserted mid-GRANT with ost_cnt=2 -> next cycle all outputs 0, ptr=0, err_o=0;
//    perf counters 0 when MEM_BUS_ARB_PERF_EN is set.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the accelerator memory-port arbiter: FSM encodings,
// default geometry and a one-hot to index helper.
package mem_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int NREQ_DEF    = 3;
  localparam int AW_DEF      = 32;
  localparam int DW_DEF      = 32;
  localparam int OST_MAX_DEF = 4;
  localparam int MAX_REQ     = 32;

  function automatic int onehot2idx(input logic [MAX_REQ-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational round-robin picker: first active request at or after ptr,
// wrapping around the requester vector.
module mem_rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [PW-1:0]   win_idx,
  output logic            any
);

  always_comb begin
    int j;
    j       = 0;
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        win_oh[j] = 1'b1;
        win_idx   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arb.sv
// Round-robin session arbiter for the shared accelerator memory port with
// outstanding-response tracking. Define MEM_BUS_ARB_PERF_EN for per-requester busy counters.
module mem_bus_arb
  import mem_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int OST_MAX = OST_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    cmd_vld_i,
  output logic [NREQ-1:0]    cmd_rdy_o,
  input  logic [NREQ*AW-1:0] cmd_addr_i,
  input  logic [NREQ*DW-1:0] cmd_data_i,
  input  logic [NREQ-1:0]    cmd_we_i,
  output logic [NREQ-1:0]    rsp_vld_o,
  input  logic [NREQ-1:0]    rsp_rdy_i,
  output logic [DW-1:0]      rsp_data_o,
  output logic             mem_cmd_vld_o,
  input  logic             mem_cmd_rdy_i,
  output logic [AW-1:0]    mem_cmd_addr_o,
  output logic [DW-1:0]    mem_cmd_data_o,
  output logic             mem_cmd_we_o,
  input  logic             mem_rsp_vld_i,
  output logic             mem_rsp_rdy_o,
  input  logic [DW-1:0]    mem_rsp_data_i,
  output logic [NREQ-1:0]  grant_o,
  output logic             err_o
`ifdef MEM_BUS_ARB_PERF_EN
  ,
  output logic [NREQ*32-1:0] perf_busy_o
`endif
);

  localparam int OSTW = $clog2(OST_MAX + 1);
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]      state;
  logic [NREQ-1:0] grant_q;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   own;
  logic [OSTW-1:0] ost_cnt;
  logic [OSTW-1:0] ost_nxt;
  logic            err_q;

  logic [NREQ-1:0] pick_oh;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;

  logic cmd_open;
  logic rsp_route;
  logic cmd_hs;
  logic rsp_hs;
  logic spurious;

  mem_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req     (req_i),
    .ptr     (ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  assign own        = PW'(onehot2idx(MAX_REQ'(grant_q)));
  assign grant_o    = grant_q;
  assign err_o      = err_q;
  assign rsp_data_o = mem_rsp_data_i;

  // Commands only flow while owning in GRANT with room left; responses with
  // nothing outstanding are swallowed and flagged rather than routed.
  assign cmd_open  = (state == GRANT) && (ost_cnt < OSTW'(OST_MAX));
  assign rsp_route = ((state == GRANT) || (state == DRAIN)) && (ost_cnt != '0);

  always_comb begin
    cmd_rdy_o      = '0;
    rsp_vld_o      = '0;
    mem_cmd_vld_o  = cmd_open & cmd_vld_i[own];
    mem_cmd_addr_o = '0;
    mem_cmd_data_o = '0;
    mem_cmd_we_o   = 1'b0;
    mem_rsp_rdy_o  = mem_rsp_vld_i;
    if (state == GRANT) begin
      mem_cmd_addr_o = cmd_addr_i[own*AW +: AW];
      mem_cmd_data_o = cmd_data_i[own*DW +: DW];
      mem_cmd_we_o   = cmd_we_i[own];
    end
    if (cmd_open) cmd_rdy_o[own] = mem_cmd_rdy_i;
    if (rsp_route) begin
      rsp_vld_o[own] = mem_rsp_vld_i;
      mem_rsp_rdy_o  = rsp_rdy_i[own];
    end
  end

  assign cmd_hs   = mem_cmd_vld_o & mem_cmd_rdy_i;
  assign rsp_hs   = rsp_route & mem_rsp_vld_i & rsp_rdy_i[own];
  assign spurious = ~rsp_route & mem_rsp_vld_i;

  always_comb begin
    ost_nxt = ost_cnt;
    if (cmd_hs && !rsp_hs)      ost_nxt = ost_cnt + OSTW'(1);
    else if (!cmd_hs && rsp_hs) ost_nxt = ost_cnt - OSTW'(1);
  end

  // Session FSM; release decisions use the post-update count so a final
  // response and the req drop may land in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= '0;
      ptr     <= '0;
      ost_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      ost_cnt <= ost_nxt;
      if (spurious) err_q <= 1'b1;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_q <= pick_oh;
            ptr     <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (!req_i[own]) begin
            if (ost_nxt == '0) begin
              state   <= IDLE;
              grant_q <= '0;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (ost_nxt == '0) begin
            state   <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

`ifdef MEM_BUS_ARB_PERF_EN
  logic [NREQ-1:0][31:0] perf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (grant_q[k] && (perf_q[k] != 32'hFFFF_FFFF)) perf_q[k] <= perf_q[k] + 32'd1;
      end
    end
  end

  assign perf_busy_o = perf_q;
`endif

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed self-checking bench for mem_bus_arb: sessions, round-robin order,
// outstanding limit, drain, spurious responses and mid-session reset.
module tb_mem_bus_arb;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_i, cmd_vld_i, cmd_rdy_o, cmd_we_i, rsp_vld_o, rsp_rdy_i, grant_o;
  logic [95:0] cmd_addr_i, cmd_data_i;
  logic [31:0] rsp_data_o, mem_cmd_addr_o, mem_cmd_data_o, mem_rsp_data_i;
  logic        mem_cmd_vld_o, mem_cmd_rdy_i, mem_cmd_we_o;
  logic        mem_rsp_vld_i, mem_rsp_rdy_o, err_o;
`ifdef MEM_BUS_ARB_PERF_EN
  logic [95:0] perf_busy_o;
`endif

  int checks = 0;
  int errors = 0;
  int acc;
  logic [2:0] oh;
  int order [4] = '{0, 1, 2, 0};

  mem_bus_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .cmd_vld_i(cmd_vld_i), .cmd_rdy_o(cmd_rdy_o),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_we_i(cmd_we_i),
    .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i), .rsp_data_o(rsp_data_o),
    .mem_cmd_vld_o(mem_cmd_vld_o), .mem_cmd_rdy_i(mem_cmd_rdy_i),
    .mem_cmd_addr_o(mem_cmd_addr_o), .mem_cmd_data_o(mem_cmd_data_o),
    .mem_cmd_we_o(mem_cmd_we_o), .mem_rsp_vld_i(mem_rsp_vld_i),
    .mem_rsp_rdy_o(mem_rsp_rdy_o), .mem_rsp_data_i(mem_rsp_data_i),
    .grant_o(grant_o), .err_o(err_o)
`ifdef MEM_BUS_ARB_PERF_EN
    , .perf_busy_o(perf_busy_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the clock edge; outputs are read 2 units later.
  task automatic applyStimulus(input logic [2:0] req, input logic [2:0] cvld, input logic mcrdy,
                               input logic mrvld, input logic [2:0] rrdy);
    req_i         = req;
    cmd_vld_i     = cvld;
    mem_cmd_rdy_i = mcrdy;
    mem_rsp_vld_i = mrvld;
    rsp_rdy_i     = rrdy;
    #2;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setCmd(input int k, input logic [31:0] addr, input logic [31:0] data, input logic we);
    cmd_addr_i[k*32 +: 32] = addr;
    cmd_data_i[k*32 +: 32] = data;
    cmd_we_i[k]            = we;
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_addr_i = '0; cmd_data_i = '0; cmd_we_i = '0; mem_rsp_data_i = '0;
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    cyc(); cyc();
    checkOutput("rst_grant", grant_o, 3'b000);
    checkOutput("rst_err", err_o, 1'b0);
    checkOutput("rst_vldrdy", {mem_cmd_vld_o, cmd_rdy_o, rsp_vld_o, mem_rsp_rdy_o}, 8'h00);
`ifdef MEM_BUS_ARB_PERF_EN
    checkOutput("rst_perf", perf_busy_o[63:0], 64'h0);
`endif
    rst_n = 1'b1;

    // Single requester: 8 writes pass through, then release
    applyStimulus(3'b100, 3'b000, 1'b1, 1'b0, 3'b000);
    checkOutput("t1_nogrant", grant_o, 3'b000);
    cyc();
    checkOutput("t1_grant", grant_o, 3'b100);
    for (int i = 0; i < 8; i++) begin
      setCmd(2, 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1);
      applyStimulus(3'b100, 3'b100, 1'b1, 1'b0, 3'b000);
      checkOutput("t1_addr", mem_cmd_addr_o, 32'h1000 + 32'(4 * i));
      checkOutput("t1_data_we", {mem_cmd_we_o, mem_cmd_data_o}, {1'b1, 32'hA0 + 32'(i)});
      checkOutput("t1_cmd_hs", {mem_cmd_vld_o, cmd_rdy_o}, 4'b1100);
      cyc();
      mem_rsp_data_i = 32'hD000 + 32'(i);
      applyStimulus(3'b100, 3'b000, 1'b1, 1'b1, 3'b100);
      checkOutput("t1_rsp", {rsp_vld_o, mem_rsp_rdy_o}, 4'b1001);
      checkOutput("t1_rsp_data", rsp_data_o, 32'hD000 + 32'(i));
      cyc();
    end
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    cyc();
    checkOutput("t1_release", grant_o, 3'b000);
    checkOutput("t1_err", err_o, 1'b0);

    // Contention: grant order 0,1,2,0 then only req1
    applyStimulus(3'b111, 3'b000, 1'b0, 1'b0, 3'b000);
    cyc();
    for (int s = 0; s < 4; s++) begin
      oh = 3'b001 << order[s];
      checkOutput("t2_grant", grant_o, oh);
      for (int c = 0; c < 2; c++) begin
        setCmd(order[s], 32'h2000 + 32'(16 * s + c), 32'h0, 1'b0);
        applyStimulus(3'b111, oh, 1'b1, 1'b0, 3'b000);
        checkOutput("t2_cmd_rdy", cmd_rdy_o, oh);
        cyc();
        applyStimulus(3'b111, 3'b000, 1'b1, 1'b1, oh);
        checkOutput("t2_rsp_vld", rsp_vld_o, oh);
        cyc();
      end
      applyStimulus(3'b111 & ~oh, 3'b000, 1'b0, 1'b0, 3'b000);
      cyc();
      checkOutput("t2_idle", grant_o, 3'b000);
      if (s < 3) applyStimulus(3'b111, 3'b000, 1'b0, 1'b0, 3'b000);
      else       applyStimulus(3'b010, 3'b000, 1'b0, 1'b0, 3'b000);
      cyc();
    end
    checkOutput("t2_wrap", grant_o, 3'b010);

    // Backpressure: outstanding limit of 4
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(3'b010, 3'b010, 1'b1, 1'b0, 3'b000);
      if (cmd_rdy_o[1]) acc++;
      cyc();
    end
    checkOutput("t3_accepted", 64'(acc), 64'd4);
    applyStimulus(3'b010, 3'b010, 1'b1, 1'b0, 3'b000);
    checkOutput("t3_full", {mem_cmd_vld_o, cmd_rdy_o}, 4'b0000);
    applyStimulus(3'b010, 3'b010, 1'b1, 1'b1, 3'b010);
    checkOutput("t3_sim4", {cmd_rdy_o, rsp_vld_o}, 6'b000_010);
    cyc();
    applyStimulus(3'b010, 3'b010, 1'b1, 1'b0, 3'b000);
    checkOutput("t3_one_more", cmd_rdy_o, 3'b010);
    cyc();
    applyStimulus(3'b010, 3'b010, 1'b1, 1'b0, 3'b000);
    checkOutput("t3_full_again", cmd_rdy_o, 3'b000);
    applyStimulus(3'b010, 3'b000, 1'b1, 1'b1, 3'b010);
    cyc(); cyc();
    applyStimulus(3'b010, 3'b010, 1'b1, 1'b1, 3'b010);
    checkOutput("t3_sim2", {cmd_rdy_o, rsp_vld_o}, 6'b010_010);
    cyc();
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(3'b010, 3'b010, 1'b1, 1'b0, 3'b000);
      if (cmd_rdy_o[1]) acc++;
      cyc();
    end
    checkOutput("t3_room_after_sim", 64'(acc), 64'd2);
    applyStimulus(3'b010, 3'b000, 1'b1, 1'b1, 3'b010);
    cyc();

    // Drain with 3 outstanding while requester 0 waits
    applyStimulus(3'b001, 3'b000, 1'b1, 1'b0, 3'b000);
    cyc();
    applyStimulus(3'b001, 3'b010, 1'b1, 1'b0, 3'b000);
    checkOutput("t4_grant_held", grant_o, 3'b010);
    checkOutput("t4_no_cmd", {mem_cmd_vld_o, cmd_rdy_o}, 4'b0000);
    for (int r = 0; r < 3; r++) begin
      applyStimulus(3'b001, 3'b010, 1'b1, 1'b1, 3'b010);
      checkOutput("t4_rsp_vld", rsp_vld_o, 3'b010);
      cyc();
      checkOutput("t4_grant", grant_o, (r < 2) ? 3'b010 : 3'b000);
    end
    applyStimulus(3'b001, 3'b000, 1'b0, 1'b0, 3'b000);
    cyc();
    checkOutput("t4_next_owner", grant_o, 3'b001);

    // Spurious response in IDLE
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    cyc();
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 3'b000);
    checkOutput("t5_spur_route", {rsp_vld_o, mem_rsp_rdy_o, err_o}, 5'b000_1_0);
    cyc();
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
    checkOutput("t5_err", err_o, 1'b1);

    // Reset mid-GRANT with 2 outstanding
    applyStimulus(3'b010, 3'b000, 1'b0, 1'b0, 3'b000);
    cyc();
    checkOutput("t6_grant", grant_o, 3'b010);
    applyStimulus(3'b010, 3'b010, 1'b1, 1'b0, 3'b000);
    cyc(); cyc();
    rst_n = 1'b0;
    cyc();
    checkOutput("t6_rst_grant_err", {grant_o, err_o}, 4'b0000);
    checkOutput("t6_rst_vldrdy", {mem_cmd_vld_o, cmd_rdy_o, rsp_vld_o, mem_rsp_rdy_o}, 8'h00);
`ifdef MEM_BUS_ARB_PERF_EN
    checkOutput("t6_rst_perf", perf_busy_o[63:0], 64'h0);
`endif
    rst_n = 1'b1;
    applyStimulus(3'b110, 3'b000, 1'b0, 1'b0, 3'b000);
    cyc();
    checkOutput("t6_ptr_reset", grant_o, 3'b010);
    applyStimulus(3'b110, 3'b000, 1'b0, 1'b1, 3'b010);
    checkOutput("t6_ost_reset", {rsp_vld_o, mem_rsp_rdy_o}, 4'b0001);
    cyc();
    checkOutput("t6_err", err_o, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
